// File: rtl/riscv_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins by default; a starvation counter forces fetch through after STARVE_MAX lost rounds.
module riscv_mem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_if_req,
    input  logic [DATA_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [3:0]        i_dm_be,
    input  logic [DATA_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic              o_dm_gnt,
    output logic              o_dm_rvalid,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_stall_f,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic       OWN_IF = 1'b0;
    localparam logic       OWN_DM = 1'b1;
    localparam logic [3:0] W_MAX  = 4'(STARVE_MAX);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_owner;
    logic       w_owner_next;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_next;

    logic w_sel_dm;
    logic w_sel_any;
    logic w_act_owner;
    logic w_drive;
    logic w_rsp;

    // Fetch only overrides data once it has lost STARVE_MAX rounds in a row.
    assign w_sel_dm  = i_dm_req & ~(i_if_req & (r_starve_cnt == W_MAX));
    assign w_sel_any = i_dm_req | i_if_req;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_IF;
            r_starve_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_owner_next  = r_owner;
        w_starve_next = r_starve_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_sel_any) begin
                    w_owner_next = w_sel_dm ? OWN_DM : OWN_IF;
                    w_state_next = i_mem_gnt ? S_WAIT : S_REQ;
                    if (w_sel_dm) begin
                        if (i_if_req && (r_starve_cnt != W_MAX)) begin
                            w_starve_next = r_starve_cnt + 4'd1;
                        end
                    end else begin
                        w_starve_next = 4'd0;
                    end
                end
            end
            S_REQ: begin
                if (i_mem_gnt) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_rvalid) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // In IDLE the owner is the live selection; afterwards it is the latched one.
    assign w_act_owner = (r_state == S_IDLE) ? w_sel_dm : r_owner;
    assign w_drive     = i_rstn & (((r_state == S_IDLE) & w_sel_any) | (r_state == S_REQ));
    assign w_rsp       = i_rstn & (r_state == S_WAIT) & i_mem_rvalid;

    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_be    = 4'h0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_if_gnt    = 1'b0;
        o_dm_gnt    = 1'b0;
        o_if_rvalid = 1'b0;
        o_if_rdata  = '0;
        o_dm_rvalid = 1'b0;
        o_dm_rdata  = '0;
        if (w_drive) begin
            o_mem_req = 1'b1;
            if (w_act_owner == OWN_DM) begin
                o_mem_we    = i_dm_we;
                o_mem_be    = i_dm_be;
                o_mem_addr  = i_dm_addr;
                o_mem_wdata = i_dm_wdata;
                o_dm_gnt    = i_mem_gnt;
            end else begin
                o_mem_be    = 4'hF;
                o_mem_addr  = i_if_addr;
                o_if_gnt    = i_mem_gnt;
            end
        end
        if (w_rsp) begin
            if (r_owner == OWN_DM) begin
                o_dm_rvalid = 1'b1;
                o_dm_rdata  = i_mem_rdata;
            end else begin
                o_if_rvalid = 1'b1;
                o_if_rdata  = i_mem_rdata;
            end
        end
    end

    assign o_stall_f = i_rstn & i_if_req & ~o_if_gnt;
    assign o_busy    = i_rstn & (r_state != S_IDLE);

endmodule
